rr_arbiter_4: RTL

//  4-requester round-robin arbiter with grant lock and hold timeout.

---
 rtl/rr_arbiter_4_pkg.sv | 21 ++
 rtl/rr_arbiter_4_pick.sv | 26 ++
 rtl/rr_arbiter_4.sv | 103 ++++++++++
 3 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter: state encoding,
// requester count and a one-hot to index helper.
package rr_arbiter_4_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [1:0] oh2idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_pick.sv
// Combinational rotate-priority picker: first requester at or after ptr wins.
module rr_pick4
    import rr_arbiter_4_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] win_oh,
    output logic            hit
);

    logic [1:0] idx;

    always_comb begin
        win_oh = '0;
        hit    = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!hit && req[idx]) begin
                win_oh[idx] = 1'b1;
                hit         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with grant lock and hold timeout.
// Grant, busy and timeout are all registered; gnt is one-hot or zero.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            timeout
);

    localparam int HW = $clog2(MAX_HOLD);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic [NREQ-1:0] win_oh;
    logic            hit;
    logic            owner_req;
    logic            expired;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .win_oh (win_oh),
        .hit    (hit)
    );

    assign owner_req = |(req & gnt_q);
    assign expired   = (hold_cnt_q == HW'(MAX_HOLD - 1));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d    = ST_GRANT;
                    gnt_d      = win_oh;
                    ptr_d      = oh2idx(win_oh) + 2'd1;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (owner_req && !expired) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end else if (hit) begin
                    // On expiry the owner sits at lowest priority since ptr
                    // already points past it; it only wins if it is alone.
                    gnt_d      = win_oh;
                    ptr_d      = oh2idx(win_oh) + 2'd1;
                    hold_cnt_d = '0;
                    timeout_d  = owner_req && (win_oh != gnt_q);
                end else begin
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
